// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer producing the CPU bus control word.
// Optional build macro: CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
//   defined   -> an instruction returns to T0 right after its last non-empty step
//   undefined -> every instruction runs all MAX_STEPS steps before wrapping
//
// State table (mode):
//   state        | meaning
//   MODE_RUN     | stepping T-states, control word decoded from step/opcode/flags
//   MODE_HALTED  | HLT executed; step frozen at 0, only o_HALT asserted
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_STEPS    = 5,
  localparam int STEP_WIDTH  = $clog2(MAX_STEPS)
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR_n,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic [1:0]              i_FLAGS,
  input  logic                    i_STEP_ENABLE,
  output logic [STEP_WIDTH-1:0]   o_STEP,
  output logic                    o_HALT,
  output logic                    o_PC_COUNT_ENABLE,
  output logic                    o_PC_WRITE_BUS,
  output logic                    o_ALU_SUBTRACT,
  output logic                    o_FLAGS_LATCH,
  output logic                    o_OUT_READ_BUS,
  output logic                    o_PC_JUMP_n,
  output logic                    o_MAR_READ_BUS_n,
  output logic                    o_RAM_READ_BUS_n,
  output logic                    o_RAM_WRITE_BUS_n,
  output logic                    o_IR_READ_BUS_n,
  output logic                    o_IR_WRITE_BUS_n,
  output logic                    o_A_READ_BUS_n,
  output logic                    o_A_WRITE_BUS_n,
  output logic                    o_B_READ_BUS_n,
  output logic                    o_ALU_WRITE_BUS_n
);

  typedef enum logic {MODE_RUN, MODE_HALTED} mode_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(MAX_STEPS - 1);

  mode_t                 mode;
  logic [STEP_WIDTH-1:0] step_q;
  logic [3:0]            op;

  // internal active-high control word
  logic halt, pc_cnt, pc_wr, alu_sub, fl_latch, out_rd, pc_jump;
  logic mar_rd, ram_rd, ram_wr, ir_rd, ir_wr, a_rd, a_wr, b_rd, alu_wr;

  // Opcodes wider than a nibble with any upper bit set fold to NOP (0).
  generate
    if (OPCODE_WIDTH > 4) begin : g_wide_op
      assign op = (|i_OPCODE[OPCODE_WIDTH-1:4]) ? 4'h0 : i_OPCODE[3:0];
    end else begin : g_nibble_op
      assign op = i_OPCODE[3:0];
    end
  endgenerate

  // Microcode decode: step, opcode, flags and halted mode into the control word.
  always_comb begin
    halt = 1'b0; pc_cnt = 1'b0; pc_wr = 1'b0; alu_sub = 1'b0; fl_latch = 1'b0;
    out_rd = 1'b0; pc_jump = 1'b0; mar_rd = 1'b0; ram_rd = 1'b0; ram_wr = 1'b0;
    ir_rd = 1'b0; ir_wr = 1'b0; a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; alu_wr = 1'b0;
    if (mode == MODE_HALTED) begin
      halt = 1'b1;
    end else begin
      case (int'(step_q))
        0: begin
          pc_wr  = 1'b1;
          mar_rd = 1'b1;
        end
        1: begin
          ram_wr = 1'b1;
          ir_rd  = 1'b1;
          pc_cnt = 1'b1;
        end
        2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_wr = 1'b1; mar_rd = 1'b1; end
            OP_LDI: begin ir_wr = 1'b1; a_rd = 1'b1; end
            OP_JMP: begin ir_wr = 1'b1; pc_jump = 1'b1; end
            OP_JC:  begin ir_wr = i_FLAGS[0]; pc_jump = i_FLAGS[0]; end
            OP_JZ:  begin ir_wr = i_FLAGS[1]; pc_jump = i_FLAGS[1]; end
            OP_OUT: begin a_wr = 1'b1; out_rd = 1'b1; end
            OP_HLT: halt = 1'b1;
            default: ;
          endcase
        end
        3: begin
          case (op)
            OP_LDA:         begin ram_wr = 1'b1; a_rd = 1'b1; end
            OP_ADD, OP_SUB: begin ram_wr = 1'b1; b_rd = 1'b1; end
            OP_STA:         begin a_wr = 1'b1; ram_rd = 1'b1; end
            default: ;
          endcase
        end
        4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            alu_wr   = 1'b1;
            a_rd     = 1'b1;
            fl_latch = 1'b1;
            alu_sub  = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
  logic [STEP_WIDTH-1:0] last_step;

  // Last non-empty step of the current instruction; untaken jumps still end at T2.
  always_comb begin
    case (op)
      OP_LDA, OP_STA: last_step = STEP_WIDTH'(3);
      OP_ADD, OP_SUB: last_step = STEP_WIDTH'(4);
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = STEP_WIDTH'(2);
      default:        last_step = STEP_WIDTH'(1);
    endcase
  end
`endif

  // Step counter and halted mode; halt in RUN mode can only be the HLT execute step.
  always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      step_q <= '0;
      mode   <= MODE_RUN;
    end else if (i_STEP_ENABLE && mode == MODE_RUN) begin
      if (halt) begin
        mode   <= MODE_HALTED;
        step_q <= '0;
      end else if (step_q == STEP_LAST) begin
        step_q <= '0;
`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
      end else if (step_q >= last_step) begin
        step_q <= '0;
`endif
      end else begin
        step_q <= step_q + 1'b1;
      end
    end
  end

  // Outputs forced inactive while clear is held, independent of the decode.
  always_comb begin
    o_STEP            = step_q;
    o_HALT            = i_CLEAR_n & halt;
    o_PC_COUNT_ENABLE = i_CLEAR_n & pc_cnt;
    o_PC_WRITE_BUS    = i_CLEAR_n & pc_wr;
    o_ALU_SUBTRACT    = i_CLEAR_n & alu_sub;
    o_FLAGS_LATCH     = i_CLEAR_n & fl_latch;
    o_OUT_READ_BUS    = i_CLEAR_n & out_rd;
    o_PC_JUMP_n       = ~(i_CLEAR_n & pc_jump);
    o_MAR_READ_BUS_n  = ~(i_CLEAR_n & mar_rd);
    o_RAM_READ_BUS_n  = ~(i_CLEAR_n & ram_rd);
    o_RAM_WRITE_BUS_n = ~(i_CLEAR_n & ram_wr);
    o_IR_READ_BUS_n   = ~(i_CLEAR_n & ir_rd);
    o_IR_WRITE_BUS_n  = ~(i_CLEAR_n & ir_wr);
    o_A_READ_BUS_n    = ~(i_CLEAR_n & a_rd);
    o_A_WRITE_BUS_n   = ~(i_CLEAR_n & a_wr);
    o_B_READ_BUS_n    = ~(i_CLEAR_n & b_rd);
    o_ALU_WRITE_BUS_n = ~(i_CLEAR_n & alu_wr);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed test-plan steps followed by random
// opcode/flag/enable/clear traffic, checked against a behavioural model.
module tb_control_sequencer;

  localparam int MAX_STEPS = 5;
`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // control word bit positions (all active-high in the bench's view)
  localparam int B_H = 15, B_PCC = 14, B_PCW = 13, B_SUB = 12, B_FL = 11, B_OUT = 10;
  localparam int B_J = 9, B_MAR = 8, B_RAMR = 7, B_RAMW = 6, B_IRR = 5, B_IRW = 4;
  localparam int B_AR = 3, B_AW = 2, B_BR = 1, B_ALUW = 0;
  localparam logic [15:0] DRIVERS = (16'd1 << B_PCW) | (16'd1 << B_RAMW) | (16'd1 << B_IRW)
                                  | (16'd1 << B_AW) | (16'd1 << B_ALUW);

  logic       i_CLOCK = 1'b0;
  logic       i_CLEAR_n;
  logic [3:0] i_OPCODE;
  logic [1:0] i_FLAGS;
  logic       i_STEP_ENABLE;
  logic [2:0] o_STEP;
  logic o_HALT, o_PC_COUNT_ENABLE, o_PC_WRITE_BUS, o_ALU_SUBTRACT, o_FLAGS_LATCH, o_OUT_READ_BUS;
  logic o_PC_JUMP_n, o_MAR_READ_BUS_n, o_RAM_READ_BUS_n, o_RAM_WRITE_BUS_n, o_IR_READ_BUS_n;
  logic o_IR_WRITE_BUS_n, o_A_READ_BUS_n, o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_WRITE_BUS_n;

  int checks = 0;
  int errors = 0;
  int m_step = 0;
  bit m_halt = 1'b0;

  control_sequencer dut (
    .i_CLOCK(i_CLOCK), .i_CLEAR_n(i_CLEAR_n), .i_OPCODE(i_OPCODE), .i_FLAGS(i_FLAGS),
    .i_STEP_ENABLE(i_STEP_ENABLE), .o_STEP(o_STEP), .o_HALT(o_HALT),
    .o_PC_COUNT_ENABLE(o_PC_COUNT_ENABLE), .o_PC_WRITE_BUS(o_PC_WRITE_BUS),
    .o_ALU_SUBTRACT(o_ALU_SUBTRACT), .o_FLAGS_LATCH(o_FLAGS_LATCH),
    .o_OUT_READ_BUS(o_OUT_READ_BUS), .o_PC_JUMP_n(o_PC_JUMP_n),
    .o_MAR_READ_BUS_n(o_MAR_READ_BUS_n), .o_RAM_READ_BUS_n(o_RAM_READ_BUS_n),
    .o_RAM_WRITE_BUS_n(o_RAM_WRITE_BUS_n), .o_IR_READ_BUS_n(o_IR_READ_BUS_n),
    .o_IR_WRITE_BUS_n(o_IR_WRITE_BUS_n), .o_A_READ_BUS_n(o_A_READ_BUS_n),
    .o_A_WRITE_BUS_n(o_A_WRITE_BUS_n), .o_B_READ_BUS_n(o_B_READ_BUS_n),
    .o_ALU_WRITE_BUS_n(o_ALU_WRITE_BUS_n)
  );

  always #5 i_CLOCK = ~i_CLOCK;

  logic [15:0] obs_w;
  assign obs_w = {o_HALT, o_PC_COUNT_ENABLE, o_PC_WRITE_BUS, o_ALU_SUBTRACT, o_FLAGS_LATCH,
                  o_OUT_READ_BUS, ~o_PC_JUMP_n, ~o_MAR_READ_BUS_n, ~o_RAM_READ_BUS_n,
                  ~o_RAM_WRITE_BUS_n, ~o_IR_READ_BUS_n, ~o_IR_WRITE_BUS_n, ~o_A_READ_BUS_n,
                  ~o_A_WRITE_BUS_n, ~o_B_READ_BUS_n, ~o_ALU_WRITE_BUS_n};

  function automatic logic [15:0] bits2(int a, int b);
    return (16'd1 << a) | (16'd1 << b);
  endfunction

  // Expected control word straight from the instruction table.
  function automatic logic [15:0] exp_ctrl(int op, int st, logic [1:0] fl, bit h, bit clr_low);
    logic [15:0] w = '0;
    if (clr_low) return '0;
    if (h) return 16'd1 << B_H;
    if (st == 0) return bits2(B_PCW, B_MAR);
    if (st == 1) return bits2(B_RAMW, B_IRR) | (16'd1 << B_PCC);
    case (op)
      1:    if (st == 2) w = bits2(B_IRW, B_MAR); else if (st == 3) w = bits2(B_RAMW, B_AR);
      2, 3: begin
        if (st == 2) w = bits2(B_IRW, B_MAR);
        else if (st == 3) w = bits2(B_RAMW, B_BR);
        else if (st == 4) w = bits2(B_ALUW, B_AR) | (16'd1 << B_FL) | ((op == 3) ? (16'd1 << B_SUB) : 16'd0);
      end
      4:    if (st == 2) w = bits2(B_IRW, B_MAR); else if (st == 3) w = bits2(B_AW, B_RAMR);
      5:    if (st == 2) w = bits2(B_IRW, B_AR);
      6:    if (st == 2) w = bits2(B_IRW, B_J);
      7:    if (st == 2 && fl[0]) w = bits2(B_IRW, B_J);
      8:    if (st == 2 && fl[1]) w = bits2(B_IRW, B_J);
      14:   if (st == 2) w = bits2(B_AW, B_OUT);
      15:   if (st == 2) w = 16'd1 << B_H;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic int last_step(int op);
    case (op)
      1, 4: return 3;
      2, 3: return 4;
      5, 6, 7, 8, 14, 15: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check(string tag);
    logic [15:0] e;
    logic [2:0]  es;
    if (!i_CLEAR_n) begin m_step = 0; m_halt = 1'b0; end
    e  = exp_ctrl(int'(i_OPCODE), m_step, i_FLAGS, m_halt, !i_CLEAR_n);
    es = 3'(m_step);
    checks++;
    assert (o_STEP === es) else begin
      errors++; $error("FAIL %s step observed=%0d expected=%0d", tag, o_STEP, es);
    end
    checks++;
    assert (obs_w === e) else begin
      errors++; $error("FAIL %s ctrl observed=%h expected=%h", tag, obs_w, e);
    end
    checks++;
    assert (($countones(obs_w & DRIVERS) <= 1) === 1'b1) else begin
      errors++; $error("FAIL %s bus_drivers observed=%h expected=at most one", tag, obs_w & DRIVERS);
    end
  endtask

  task automatic check_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_step(string tag, int exp);
    checks++;
    assert (int'(o_STEP) === exp) else begin
      errors++; $error("FAIL %s step observed=%0d expected=%0d", tag, o_STEP, exp);
    end
  endtask

  // One rising edge; the model advances from the inputs held across that edge.
  task automatic tick();
    int ns = m_step;
    bit nh = m_halt;
    if (!i_CLEAR_n) begin
      ns = 0; nh = 1'b0;
    end else if (i_STEP_ENABLE && !m_halt) begin
      if (i_OPCODE == 4'hF && m_step == 2) begin
        nh = 1'b1; ns = 0;
      end else if (EARLY && m_step >= last_step(int'(i_OPCODE))) begin
        ns = 0;
      end else begin
        ns = (m_step + 1) % MAX_STEPS;
      end
    end
    @(posedge i_CLOCK);
    m_step = ns;
    m_halt = nh;
    #1;
  endtask

  task automatic tick_check(string tag);
    tick();
    check(tag);
  endtask

  // Asynchronous clear pulse between edges; entered 1 time unit after an edge.
  task automatic clear_pulse(string tag);
    #2 i_CLEAR_n = 1'b0;
    #1 check({tag, "_low"});
    #1 i_CLEAR_n = 1'b1;
    #1 check({tag, "_rel"});
  endtask

  initial begin
    i_CLEAR_n = 1'b0; i_OPCODE = 4'hF; i_FLAGS = 2'b11; i_STEP_ENABLE = 1'b1;
    #2 check("reset");
    tick_check("reset_edge");
    i_OPCODE = 4'h1; i_FLAGS = 2'b00;

    // LDA fetch
    clear_pulse("lda");
    check_bit("t0_pc_wr", o_PC_WRITE_BUS, 1'b1);
    check_bit("t0_mar_n", o_MAR_READ_BUS_n, 1'b0);
    tick_check("lda_t1");
    check_bit("t1_ram_wr_n", o_RAM_WRITE_BUS_n, 1'b0);
    check_bit("t1_ir_rd_n", o_IR_READ_BUS_n, 1'b0);
    check_bit("t1_pc_cnt", o_PC_COUNT_ENABLE, 1'b1);
    tick_check("lda_t2");
    check_step("lda_t2_step", 2);

    // SUB through T4 and back to T0
    i_OPCODE = 4'h3;
    clear_pulse("sub");
    repeat (4) tick_check("sub_run");
    check_bit("sub_alu_wr_n", o_ALU_WRITE_BUS_n, 1'b0);
    check_bit("sub_a_rd_n", o_A_READ_BUS_n, 1'b0);
    check_bit("sub_flags", o_FLAGS_LATCH, 1'b1);
    check_bit("sub_subtract", o_ALU_SUBTRACT, 1'b1);
    tick_check("sub_wrap");
    check_step("sub_wrap_step", 0);

    // LDI length depends on the early-reset build
    i_OPCODE = 4'h5;
    clear_pulse("ldi");
    repeat (3) tick_check("ldi_run");
    check_step("ldi_after3", EARLY ? 0 : 3);

    // JC / JZ taken and untaken at T2
    i_OPCODE = 4'h7; i_FLAGS = 2'b01;
    clear_pulse("jc");
    repeat (2) tick_check("jc_run");
    check_bit("jc_taken", o_PC_JUMP_n, 1'b0);
    i_FLAGS = 2'b10;
    #1 check("jc_untaken");
    check_bit("jc_untaken_j", o_PC_JUMP_n, 1'b1);
    check_bit("jc_untaken_ir", o_IR_WRITE_BUS_n, 1'b1);
    i_OPCODE = 4'h8; i_FLAGS = 2'b10;
    clear_pulse("jz");
    repeat (2) tick_check("jz_run");
    check_bit("jz_taken", o_PC_JUMP_n, 1'b0);
    i_FLAGS = 2'b01;
    #1 check("jz_untaken");
    check_bit("jz_untaken_j", o_PC_JUMP_n, 1'b1);
    check_bit("jz_untaken_ir", o_IR_WRITE_BUS_n, 1'b1);

    // HLT: frozen until clear
    i_OPCODE = 4'hF;
    clear_pulse("hlt");
    repeat (2) tick_check("hlt_run");
    check_bit("hlt_t2_halt", o_HALT, 1'b1);
    tick_check("hlt_enter");
    for (int i = 0; i < 10; i++) begin
      i_OPCODE = 4'($urandom_range(0, 15));
      i_FLAGS = 2'($urandom_range(0, 3));
      tick_check("hlt_frozen");
      check_bit("hlt_halt", o_HALT, 1'b1);
      check_step("hlt_step", 0);
    end
    i_OPCODE = 4'h1;
    clear_pulse("hlt_exit");
    check_bit("hlt_exit_halt", o_HALT, 1'b0);
    tick_check("hlt_fetch");

    // Hold in ADD T3
    i_OPCODE = 4'h2;
    clear_pulse("add");
    repeat (3) tick_check("add_run");
    i_STEP_ENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_check("add_hold");
      check_step("add_hold_step", 3);
      check_bit("add_hold_b_rd_n", o_B_READ_BUS_n, 1'b0);
    end
    i_STEP_ENABLE = 1'b1;
    tick_check("add_resume");
    check_step("add_resume_step", 4);

    // Clear mid-STA, no clock edge
    i_OPCODE = 4'h4;
    clear_pulse("sta");
    repeat (3) tick_check("sta_run");
    #2 i_CLEAR_n = 1'b0;
    #1 check("sta_clear");
    check_bit("sta_clear_a_wr_n", o_A_WRITE_BUS_n, 1'b1);
    #1 i_CLEAR_n = 1'b1;
    #1 check("sta_restart");
    check_bit("sta_restart_pc_wr", o_PC_WRITE_BUS, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      i_OPCODE      = 4'($urandom_range(0, 15));
      i_FLAGS       = 2'($urandom_range(0, 3));
      i_STEP_ENABLE = ($urandom_range(0, 9) < 8);
      i_CLEAR_n     = ($urandom_range(0, 19) != 0);
      #1 check("rand");
      tick_check("rand_edge");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit that replaces the hard-wired control strobes at the CPU top level.
- Steps a T-state counter and decodes opcode, step and flags into the full bus control word: PC, MAR, RAM, IR, A, B, ALU, flags and output register.
- Sits between the instruction register (opcode nibble) and every bus participant.
- Adds conditional jumps, halt, and optional variable-length instructions.

Parameters:
- OPCODE_WIDTH, 4, width of i_OPCODE. Any opcode value above 4'hF decodes as NOP.
- MAX_STEPS, 5, number of T-states per instruction. Must be at least 5.
- STEP_WIDTH (localparam), $clog2(MAX_STEPS), width of o_STEP.

Ports:
- i_CLOCK  in  1  CPU clock; all state changes on the rising edge.
- i_CLEAR_n  in  1  asynchronous active-low reset.
- i_OPCODE  in  OPCODE_WIDTH  opcode field of the instruction register.
- i_FLAGS  in  2  [0]=carry, [1]=zero, from the external flags register.
- i_STEP_ENABLE  in  1  1=advance step; 0=hold step and halted state.
- o_STEP  out  STEP_WIDTH  current T-state.
- o_HALT  out  1  high while halted, or during the HLT execute step; feeds the Clock halt input.
- o_PC_COUNT_ENABLE, o_PC_WRITE_BUS, o_ALU_SUBTRACT, o_FLAGS_LATCH, o_OUT_READ_BUS  out  1 each  active-high strobes.
- o_PC_JUMP_n, o_MAR_READ_BUS_n, o_RAM_READ_BUS_n, o_RAM_WRITE_BUS_n, o_IR_READ_BUS_n, o_IR_WRITE_BUS_n, o_A_READ_BUS_n, o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_WRITE_BUS_n  out  1 each  active-low strobes.

Behaviour:
- State: step register (STEP_WIDTH bits) and sticky halted bit. i_CLEAR_n low → step=0, halted=0, asynchronously.
- Reset outputs: while i_CLEAR_n is low, o_STEP=0, o_HALT=0, active-high strobes 0, active-low strobes 1, regardless of other inputs.
- Decode timing: control word is combinational from step, i_OPCODE, i_FLAGS and halted. A strobe asserted in step N is consumed by its target on the rising edge that ends step N.
- Strobes not listed for a step are inactive.
- Fetch, all opcodes:
  - T0: PC_WRITE_BUS, MAR_READ.
  - T1: RAM_WRITE, IR_READ, PC_COUNT_ENABLE.
- Execute, T2 onward:
  - 0 NOP: none.
  - 1 LDA: T2 IR_WRITE+MAR_READ; T3 RAM_WRITE+A_READ.
  - 2 ADD: T2 IR_WRITE+MAR_READ; T3 RAM_WRITE+B_READ; T4 ALU_WRITE+A_READ+FLAGS_LATCH.
  - 3 SUB: as ADD, plus ALU_SUBTRACT in T4.
  - 4 STA: T2 IR_WRITE+MAR_READ; T3 A_WRITE+RAM_READ.
  - 5 LDI: T2 IR_WRITE+A_READ.
  - 6 JMP: T2 IR_WRITE+PC_JUMP.
  - 7 JC: as JMP only if i_FLAGS[0]=1, else none.
  - 8 JZ: as JMP only if i_FLAGS[1]=1, else none.
  - E OUT: T2 A_WRITE+OUT_READ.
  - F HLT: T2 o_HALT.
  - 9–D and out-of-range opcodes: NOP.
- Step advance: on each rising edge with i_STEP_ENABLE=1 and halted=0, step increments and wraps from MAX_STEPS-1 to 0.
- Hold: i_STEP_ENABLE=0 holds step and halted; outputs keep decoding the held state.
- Halt entry: rising edge in HLT T2 with i_STEP_ENABLE=1 sets halted=1 and step=0.
- While halted:
  - o_HALT=1 and all other strobes inactive.
  - step frozen at 0.
  - only i_CLEAR_n exits halt.
- Reset mid-instruction: instruction abandoned; execution restarts at T0 fetch.
- Opcode changing mid-instruction is legal; decode follows the current i_OPCODE.
- At most one bus driver (*_WRITE_BUS) is active in any step.

Optional Feature:
- CONTROL_SEQUENCER_EARLY_STEP_RESET_EN defined:
  - After an instruction's last non-empty step, the next step is 0.
  - Last steps: NOP T1; LDA/STA T3; ADD/SUB T4; LDI/JMP/JC/JZ/OUT T2.
  - Untaken JC/JZ end at T2.
  - The MAX_STEPS wrap still applies.
- Undefined: every instruction occupies all MAX_STEPS steps, trailing steps have no strobes, and wrap is at MAX_STEPS-1.

Test Plan:
- Reset then 2 edges, opcode 1 (LDA) → T0 shows PC_WRITE_BUS=1, MAR_READ_BUS_n=0; T1 shows RAM_WRITE_BUS_n=0, IR_READ_BUS_n=0, PC_COUNT_ENABLE=1; o_STEP 0→1→2.
- Opcode 3 (SUB), run to T4 → ALU_WRITE_BUS_n=0, A_READ_BUS_n=0, FLAGS_LATCH=1, ALU_SUBTRACT=1. Macro off: o_STEP returns to 0 after 5 edges. Macro on: LDI returns to 0 after 3 edges.
- Opcode 7 (JC) at T2 with i_FLAGS=2'b01 → PC_JUMP_n=0. With i_FLAGS=2'b10 → PC_JUMP_n=1 and IR_WRITE_BUS_n=1. Repeat for opcode 8 (JZ) with inverted flags.
- Opcode F (HLT) at T2, edge → o_HALT=1, o_STEP=0 frozen for 10 edges, all strobes inactive. Pulse i_CLEAR_n=0 → o_HALT=0, fetch resumes.
- i_STEP_ENABLE=0 at T3 of ADD for 4 edges → o_STEP stays 3, B_READ_BUS_n stays 0. Re-enable → T4.
- Assert i_CLEAR_n=0 between edges in T3 of STA → o_STEP=0 and all strobes inactive immediately, without a clock edge; release → T0 fetch.
